// File: rtl/seg7_display_ctrl.sv
// Seven-segment controller: shows a loaded binary value as hex or unsigned decimal on
// NUM_DIGITS active-low HEX digits, with leading-zero blanking, blinking and overflow dashes.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       value_in,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state;
  logic [DATA_W-1:0]  bin_sr;
  logic [BCD_W-1:0]   bcd;
  logic               sticky;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BCD_W-1:0]   digits;
  logic [BLK_W-1:0]   blink_cnt;
  logic               phase;

  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_shift;
  logic               bcd_carry;
  logic [7*NUM_DIGITS-1:0] seg_next;
  logic [3:0]         nib;
  logic [6:0]         code;
  logic               lz_run;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  // One double-dabble step: add-3 correction, then shift {bcd, bin} left by one.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    bcd_carry = bcd_adj[BCD_W-1];
    bcd_shift = {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      bin_sr   <= '0;
      bcd      <= '0;
      sticky   <= 1'b0;
      bit_cnt  <= '0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            if (mode) begin
              bin_sr  <= value_in;
              bcd     <= '0;
              sticky  <= 1'b0;
              bit_cnt <= '0;
              busy    <= 1'b1;
              state   <= SHIFT;
            end else begin
              digits   <= BCD_W'(value_in);
              overflow <= 1'b0;
            end
          end
        end
        SHIFT: begin
          bin_sr  <= bin_sr << 1;
          bcd     <= bcd_shift;
          // A bit leaving the top BCD nibble means the value needs more digits than we have.
          if (bcd_carry)
            sticky <= 1'b1;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(DATA_W - 1))
            state <= DONE;
        end
        DONE: begin
          digits   <= bcd;
          overflow <= sticky;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLK_W'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Walk from the top digit down; lz_run stays high while every digit so far is zero.
  always_comb begin
    seg_next = '1;
    lz_run   = 1'b1;
    nib      = '0;
    code     = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib    = digits[4*i +: 4];
      code   = overflow ? SEG_DASH : seg_decode(nib);
      lz_run = lz_run & (nib == 4'd0);
      if ((i != 0 && lz_run && blank_lz && !overflow) || (phase && blink_en[i]))
        code = SEG_BLANK;
      seg_next[7*i +: 7] = code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      hex_out <= '1;
    else
      hex_out <= seg_next;
  end

endmodule
